// File: rtl/ex_stage.sv
// Execute stage: forwarded operands and a 32-bit ALU feed a 2-entry skid buffer
// toward the memory stage.
module ex_stage #(
    parameter bit ForwardEnable = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        flush_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] readData1_i,
    input  logic [31:0] readData2_i,
    input  logic [63:0] immediate_i,
    input  logic [63:0] PC_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic        RegWrite_i,
    input  logic        MemWrite_i,
    input  logic        MemRead_i,
    input  logic        MemToReg_i,
    input  logic        ALUSrc_i,
    input  logic [2:0]  ALUOp_i,
    input  logic [2:0]  funct3_i,
    input  logic        mem_fwd_we_i,
    input  logic [4:0]  mem_fwd_rd_i,
    input  logic [31:0] mem_fwd_data_i,
    input  logic        wb_fwd_we_i,
    input  logic [4:0]  wb_fwd_rd_i,
    input  logic [31:0] wb_fwd_data_i,
    output logic [31:0] alu_result_o,
    output logic [31:0] store_data_o,
    output logic [63:0] PC_o,
    output logic [4:0]  rd_o,
    output logic        RegWrite_o,
    output logic        MemWrite_o,
    output logic        MemRead_o,
    output logic        MemToReg_o,
    output logic [2:0]  funct3_o,
    output logic        valid_o,
    input  logic        ready_i
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [63:0] pc;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic        mem_to_reg;
        logic [2:0]  funct3;
    } entry_t;

    state_e state_q, state_d;
    entry_t main_q, main_d, skid_q, skid_d, new_entry;

    logic [31:0] op_a, fwd_b, op_b, alu;
    logic        accept, drain;

    logic unused_imm;
    assign unused_imm = ^immediate_i[63:32];

    // MEM is checked first so the younger producer wins; x0 is never forwarded.
    always_comb begin
        op_a  = readData1_i;
        fwd_b = readData2_i;
        if (ForwardEnable) begin
            if (mem_fwd_we_i && mem_fwd_rd_i == rs1_i && rs1_i != 5'd0) begin
                op_a = mem_fwd_data_i;
            end else if (wb_fwd_we_i && wb_fwd_rd_i == rs1_i && rs1_i != 5'd0) begin
                op_a = wb_fwd_data_i;
            end
            if (mem_fwd_we_i && mem_fwd_rd_i == rs2_i && rs2_i != 5'd0) begin
                fwd_b = mem_fwd_data_i;
            end else if (wb_fwd_we_i && wb_fwd_rd_i == rs2_i && rs2_i != 5'd0) begin
                fwd_b = wb_fwd_data_i;
            end
        end
    end

    assign op_b = ALUSrc_i ? immediate_i[31:0] : fwd_b;

    always_comb begin
        alu = '0;
        unique case (ALUOp_i)
            3'b000: alu = op_a + op_b;
            3'b001: alu = op_a - op_b;
            3'b010: alu = op_a & op_b;
            3'b011: alu = op_a | op_b;
            3'b100: alu = op_a ^ op_b;
            3'b101: alu = op_a << op_b[4:0];
            3'b110: alu = op_a >> op_b[4:0];
            3'b111: alu = $unsigned($signed(op_a) >>> op_b[4:0]);
            default: alu = '0;
        endcase
    end

    always_comb begin
        new_entry.alu_result = alu;
        new_entry.store_data = fwd_b;
        new_entry.pc         = PC_i;
        new_entry.rd         = rd_i;
        new_entry.reg_write  = RegWrite_i;
        new_entry.mem_write  = MemWrite_i;
        new_entry.mem_read   = MemRead_i;
        new_entry.mem_to_reg = MemToReg_i;
        new_entry.funct3     = funct3_i;
    end

    assign ready_o = (state_q != StTwo);
    assign valid_o = (state_q != StEmpty);
    assign accept  = valid_i & ready_o;
    assign drain   = valid_o & ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StOne;
                        main_d  = new_entry;
                    end
                end
                StOne: begin
                    if (accept && !drain) begin
                        state_d = StTwo;
                        skid_d  = new_entry;
                    end else if (drain && !accept) begin
                        state_d = StEmpty;
                    end else if (accept && drain) begin
                        main_d = new_entry;
                    end
                end
                StTwo: begin
                    if (drain) begin
                        state_d = StOne;
                        main_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign alu_result_o = main_q.alu_result;
    assign store_data_o = main_q.store_data;
    assign PC_o         = main_q.pc;
    assign rd_o         = main_q.rd;
    assign RegWrite_o   = main_q.reg_write;
    assign MemWrite_o   = main_q.mem_write;
    assign MemRead_o    = main_q.mem_read;
    assign MemToReg_o   = main_q.mem_to_reg;
    assign funct3_o     = main_q.funct3;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, forwarding priority, skid buffering,
// flush and reset.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset_i, flush_i, valid_i, ready_o, ready_i, valid_o;
    logic [31:0] readData1_i, readData2_i;
    logic [63:0] immediate_i, PC_i;
    logic [4:0]  rd_i, rs1_i, rs2_i;
    logic        RegWrite_i, MemWrite_i, MemRead_i, MemToReg_i, ALUSrc_i;
    logic [2:0]  ALUOp_i, funct3_i;
    logic        mem_fwd_we_i, wb_fwd_we_i;
    logic [4:0]  mem_fwd_rd_i, wb_fwd_rd_i;
    logic [31:0] mem_fwd_data_i, wb_fwd_data_i;
    logic [31:0] alu_result_o, store_data_o;
    logic [63:0] PC_o;
    logic [4:0]  rd_o;
    logic        RegWrite_o, MemWrite_o, MemRead_o, MemToReg_o;
    logic [2:0]  funct3_o;

    int checks = 0;
    int passes = 0;

    ex_stage #(.ForwardEnable(1'b1)) dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .readData1_i(readData1_i), .readData2_i(readData2_i),
        .immediate_i(immediate_i), .PC_i(PC_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .RegWrite_i(RegWrite_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
        .MemToReg_i(MemToReg_i), .ALUSrc_i(ALUSrc_i),
        .ALUOp_i(ALUOp_i), .funct3_i(funct3_i),
        .mem_fwd_we_i(mem_fwd_we_i), .mem_fwd_rd_i(mem_fwd_rd_i),
        .mem_fwd_data_i(mem_fwd_data_i),
        .wb_fwd_we_i(wb_fwd_we_i), .wb_fwd_rd_i(wb_fwd_rd_i),
        .wb_fwd_data_i(wb_fwd_data_i),
        .alu_result_o(alu_result_o), .store_data_o(store_data_o),
        .PC_o(PC_o), .rd_o(rd_o),
        .RegWrite_o(RegWrite_o), .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o),
        .MemToReg_o(MemToReg_o), .funct3_o(funct3_o),
        .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", name, got, exp);
    endtask

    task automatic instr(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic src, input logic [63:0] imm, input logic [63:0] pc);
        readData1_i = a;
        readData2_i = b;
        ALUOp_i     = op;
        ALUSrc_i    = src;
        immediate_i = imm;
        PC_i        = pc;
        rd_i        = 5'd3;
        rs1_i       = 5'd1;
        rs2_i       = 5'd2;
        RegWrite_i  = 1'b1;
        funct3_i    = 3'b010;
        valid_i     = 1'b1;
    endtask

    initial begin
        reset_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        readData1_i = '0; readData2_i = '0; immediate_i = '0; PC_i = '0;
        rd_i = '0; rs1_i = '0; rs2_i = '0;
        RegWrite_i = 1'b0; MemWrite_i = 1'b0; MemRead_i = 1'b0; MemToReg_i = 1'b0;
        ALUSrc_i = 1'b0; ALUOp_i = '0; funct3_i = '0;
        mem_fwd_we_i = 1'b0; mem_fwd_rd_i = '0; mem_fwd_data_i = '0;
        wb_fwd_we_i = 1'b0; wb_fwd_rd_i = '0; wb_fwd_data_i = '0;

        // Reset state
        tick(); tick();
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_alu", alu_result_o, 0);
        check("rst_pc", PC_o, 0);
        reset_i = 1'b1;

        // ADD wraps into the sign bit
        instr(32'h7FFF_FFFF, 32'h1, 3'b000, 1'b0, 64'h0, 64'h1000);
        tick();
        check("add_valid", valid_o, 1);
        check("add_result", alu_result_o, 32'h8000_0000);
        check("add_pc", PC_o, 64'h1000);
        check("add_rd", rd_o, 3);
        check("add_store", store_data_o, 32'h1);
        check("add_funct3", funct3_o, 3'b010);

        // Forwarding: MEM beats WB, x0 never forwarded
        instr(32'h11, 32'h0, 3'b000, 1'b0, 64'h0, 64'h1004);
        rs1_i = 5'd5; rs2_i = 5'd0;
        mem_fwd_we_i = 1'b1; mem_fwd_rd_i = 5'd5; mem_fwd_data_i = 32'hAA;
        wb_fwd_we_i = 1'b1; wb_fwd_rd_i = 5'd5; wb_fwd_data_i = 32'hBB;
        tick();
        check("fwd_mem_prio", alu_result_o, 32'hAA);
        rs1_i = 5'd0;
        tick();
        check("fwd_rs1_zero", alu_result_o, 32'h11);
        rs1_i = 5'd5; mem_fwd_we_i = 1'b0;
        tick();
        check("fwd_wb_only", alu_result_o, 32'hBB);
        rs1_i = 5'd0; rs2_i = 5'd5; mem_fwd_we_i = 1'b1;
        tick();
        check("fwd_rs2_alu", alu_result_o, 32'hBB);
        check("fwd_rs2_store", store_data_o, 32'hAA);
        mem_fwd_we_i = 1'b0; wb_fwd_we_i = 1'b0;

        // Other ALU ops
        instr(32'h5, 32'h7, 3'b001, 1'b0, 64'h0, 64'h1008);
        tick();
        check("sub", alu_result_o, 32'hFFFF_FFFE);
        instr(32'hF0F0_1234, 32'h0FF0_FFFF, 3'b010, 1'b0, 64'h0, 64'h100C);
        tick();
        check("and", alu_result_o, 32'h00F0_1234);
        instr(32'hF000_0000, 32'h0000_000F, 3'b011, 1'b0, 64'h0, 64'h1010);
        tick();
        check("or", alu_result_o, 32'hF000_000F);
        instr(32'hFFFF_0000, 32'h0F0F_0F0F, 3'b100, 1'b0, 64'h0, 64'h1014);
        tick();
        check("xor", alu_result_o, 32'hF0F0_0F0F);
        instr(32'h1, 32'h0, 3'b101, 1'b1, 64'h3F, 64'h1018);
        tick();
        check("sll", alu_result_o, 32'h8000_0000);
        instr(32'h8000_0000, 32'h0, 3'b110, 1'b1, 64'h4, 64'h101C);
        tick();
        check("srl", alu_result_o, 32'h0800_0000);
        instr(32'h8000_0000, 32'h0, 3'b111, 1'b1, 64'd33, 64'h1020);
        tick();
        check("sra", alu_result_o, 32'hC000_0000);
        valid_i = 1'b0;
        tick();
        check("drain_empty", valid_o, 0);

        // Backpressure: A, B held, C refused, then in-order drain
        ready_i = 1'b0;
        instr(32'hA, 32'h0, 3'b000, 1'b0, 64'h0, 64'h2000);
        tick();
        check("bp_a_valid", valid_o, 1);
        check("bp_ready1", ready_o, 1);
        instr(32'hB, 32'h0, 3'b000, 1'b0, 64'h0, 64'h2004);
        tick();
        check("bp_ready2", ready_o, 0);
        check("bp_hold_a", alu_result_o, 32'hA);
        instr(32'hC, 32'h0, 3'b000, 1'b0, 64'h0, 64'h2008);
        tick();
        check("bp_c_refused", ready_o, 0);
        check("bp_stable_a", alu_result_o, 32'hA);
        check("bp_stable_pc", PC_o, 64'h2000);
        ready_i = 1'b1;
        tick();
        check("bp_out_b", alu_result_o, 32'hB);
        check("bp_ready3", ready_o, 1);
        tick();
        check("bp_out_c", alu_result_o, 32'hC);
        check("bp_pc_c", PC_o, 64'h2008);
        valid_i = 1'b0;
        tick();
        check("bp_done", valid_o, 0);

        // Flush from TWO with an incoming beat
        ready_i = 1'b0;
        instr(32'h51, 32'h0, 3'b000, 1'b0, 64'h0, 64'h3000);
        tick();
        instr(32'h52, 32'h0, 3'b000, 1'b0, 64'h0, 64'h3004);
        tick();
        check("fl_two", ready_o, 0);
        instr(32'h53, 32'h0, 3'b000, 1'b0, 64'h0, 64'h3008);
        flush_i = 1'b1;
        tick();
        check("fl_valid", valid_o, 0);
        check("fl_ready", ready_o, 1);
        flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        tick();
        check("fl_stay_empty", valid_o, 0);
        instr(32'h77, 32'h0, 3'b000, 1'b0, 64'h0, 64'h300C);
        tick();
        check("fl_next", alu_result_o, 32'h77);
        valid_i = 1'b0;
        tick();
        check("fl_no_ghost", valid_o, 0);

        // Reset while ONE, with a beat offered
        ready_i = 1'b0;
        instr(32'h99, 32'h1, 3'b000, 1'b0, 64'h0, 64'h4000);
        MemWrite_i = 1'b1;
        tick();
        check("rs_one", valid_o, 1);
        check("rs_mw_before", MemWrite_o, 1);
        reset_i = 1'b0;
        tick();
        check("rs_valid", valid_o, 0);
        check("rs_ready", ready_o, 1);
        check("rs_alu", alu_result_o, 0);
        check("rs_store", store_data_o, 0);
        check("rs_pc", PC_o, 0);
        check("rs_rd", rd_o, 0);
        check("rs_ctrl", {RegWrite_o, MemWrite_o, MemRead_o, MemToReg_o, funct3_o}, 0);
        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        tick();
        check("rs_after", valid_o, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter ForwardEnable, default 1, meaning: 1 = MEM/WB operand forwarding active; 0 = register-file operands used unmodified.
REQ-002 Ports, one per line, as name / direction / width / meaning:
- clk_i  in  1  sole clock; all state updates on posedge.
- reset_i  in  1  reset, synchronous and active-low.
- flush_i  in  1  discard all held and incoming instructions.
- valid_i / ready_o  in / out  1 / 1  upstream handshake from decode/execute register.
- readData1_i, readData2_i  in  32 each  register-file operands.
- immediate_i  in  64  sign-extended immediate; only [31:0] used.
- PC_i  in  64  instruction PC.
- rd_i, rs1_i, rs2_i  in  5 each  register indices.
- RegWrite_i, MemWrite_i, MemRead_i, MemToReg_i, ALUSrc_i  in  1 each  control bits.
- ALUOp_i, funct3_i  in  3 each  ALU select; memory access width.
- mem_fwd_we_i, mem_fwd_rd_i, mem_fwd_data_i  in  1/5/32  MEM-stage writeback candidate.
- wb_fwd_we_i, wb_fwd_rd_i, wb_fwd_data_i  in  1/5/32  WB-stage writeback candidate.
- alu_result_o, store_data_o  out  32 each  registered ALU result; forwarded rs2 value.
- PC_o  out  64  registered PC.
- rd_o  out  5  registered destination.
- RegWrite_o, MemWrite_o, MemRead_o, MemToReg_o  out  1 each  registered control.
- funct3_o  out  3  registered access width.
- valid_o / ready_i  out / in  1 / 1  downstream handshake toward memory stage.

Function
REQ-003 Forwarding, per operand, when ForwardEnable=1: if mem_fwd_we_i and mem_fwd_rd_i == rsN_i != 0, use mem_fwd_data_i; else if wb_fwd_we_i and wb_fwd_rd_i == rsN_i != 0, use wb_fwd_data_i; else use readDataN_i.
- MEM SHALL win when both stages match.
- rsN_i == 0 SHALL never be forwarded.
REQ-004 Operand B SHALL be immediate_i[31:0] when ALUSrc_i=1, else forwarded rs2.
- store_data_o SHALL always carry forwarded rs2.
REQ-005 ALUOp encoding, 32-bit with result wrapping modulo 2^32 and no overflow flag:
- 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
- 101 SLL, 110 SRL, 111 SRA; shift amount is B[4:0].
REQ-006 Result and passthrough fields SHALL be computed combinationally from stage inputs and captured on accept, giving 1-cycle latency from accept to valid_o.
REQ-007 Output buffer SHALL be a 2-entry skid buffer (main, skid) with states EMPTY, ONE, TWO; outputs always present the main entry.
REQ-008 ready_o SHALL equal (state != TWO) and be a function of registered state only.
- valid_o SHALL equal (state != EMPTY).
REQ-009 Accept = valid_i & ready_o; drain = valid_o & ready_i.
REQ-010 State transitions:
- EMPTY: accept -> ONE (write main).
- ONE: accept & !drain -> TWO (write skid); drain & !accept -> EMPTY; accept & drain -> ONE (main overwritten with new); neither -> ONE.
- TWO: drain -> ONE (skid moves to main); no accept possible.
REQ-011 Order SHALL be preserved.
- No entry SHALL be dropped or duplicated without flush.
- Output fields SHALL stay stable while valid_o & !ready_i.
REQ-012 flush_i=1 SHALL force state EMPTY on the next edge and discard any same-cycle input.
- ready_o keeps its state-based value during flush.
- flush has priority over accept and drain.

Reset
REQ-013 While reset_i=0 at posedge:
- state SHALL become EMPTY, so valid_o=0 and ready_o=1.
- All data and control outputs SHALL be cleared to 0.
REQ-014 Reset SHALL override flush and handshakes.
- Reset mid-operation SHALL discard both entries.

Verification
REQ-015 Scenarios the bench SHALL cover:
- ADD: rs1=0x7FFFFFFF, rs2=1, ALUOp=000, ALUSrc=0, ready_i=1 -> next cycle valid_o=1, alu_result_o=0x80000000.
- Forward priority: rs1=5; MEM (we=1, rd=5, 0xAA); WB (we=1, rd=5, 0xBB); readData1=0x11; ALUOp=000; B=0 -> result 0xAA. Same with rs1=0 -> 0x11.
- Backpressure: ready_i=0, three valid_i beats A,B,C -> A,B held; ready_o=0 after second accept; C not accepted. Then ready_i=1 -> A, B, C emerge in order.
- SRA: rs1=0x80000000, imm=33, ALUSrc=1, ALUOp=111 -> 0xC0000000 (shift 1).
- Flush with state TWO and valid_i=1 -> next cycle valid_o=0, ready_o=1; later outputs contain none of the flushed instructions.
- reset_i=0 for one cycle while state ONE -> valid_o=0, all outputs 0, ready_o=1.
